// File: rtl/key_command_scheduler_if.sv
// Command handshake between the key scheduler (master) and its consumer (slave).
interface key_command_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_key;
    logic       cmd_repeat;

    modport master (output cmd_valid, cmd_key, cmd_repeat, input cmd_ready);
    modport slave  (input cmd_valid, cmd_key, cmd_repeat, output cmd_ready);
endinterface

// File: rtl/key_command_scheduler.sv
// Four-key press/auto-repeat event generator feeding a single round-robin
// arbitrated command register with a valid/ready handshake.
module key_command_scheduler #(
    parameter int CNT_W         = 24,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [3:0]                    keyIn,
    input  logic                          enable,
    output logic                          dropped,
    key_command_scheduler_if.master       cmd
);
    localparam int NUM_KEYS = 4;
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t               state_q [NUM_KEYS];
    state_t               state_d [NUM_KEYS];
    logic [CNT_W-1:0]     cnt_q   [NUM_KEYS];
    logic [CNT_W-1:0]     cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0]  key_q, rise, ev, ev_rep;
    logic [NUM_KEYS-1:0]  pending_q, pending_d, pend_rep_q, pend_rep_d, gnt_vec;
    logic [1:0]           ptr_q, gnt_idx, idx;
    logic                 gnt_any, load, drop_d;

    // key_q resets high so a key held through reset never looks like a fresh press
    assign rise = keyIn & ~key_q;

    always_comb begin
        ev     = '0;
        ev_rep = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!keyIn[i] || !enable) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    IDLE: if (rise[i]) begin
                        state_d[i] = DELAY;
                        cnt_d[i]   = '0;
                        ev[i]      = 1'b1;
                    end
                    DELAY: if (cnt_q[i] == DLY_LAST) begin
                        state_d[i] = REPEAT;
                        cnt_d[i]   = '0;
                        ev[i]      = 1'b1;
                        ev_rep[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                    REPEAT: if (cnt_q[i] == PER_LAST) begin
                        cnt_d[i]  = '0;
                        ev[i]     = 1'b1;
                        ev_rep[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Round-robin search starting at ptr_q, wrapping 3 -> 0
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        idx     = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            idx = ptr_q + 2'(k);
            if (!gnt_any && pending_q[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign load    = enable && gnt_any && (!cmd.cmd_valid || cmd.cmd_ready);
    assign gnt_vec = load ? (4'b0001 << gnt_idx) : 4'b0000;

    // A new event beats the clear of its own grant; otherwise a busy slot drops it
    always_comb begin
        pending_d  = pending_q;
        pend_rep_d = pend_rep_q;
        drop_d     = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (gnt_vec[i]) pending_d[i] = 1'b0;
            if (ev[i]) begin
                if (!pending_q[i] || gnt_vec[i]) begin
                    pending_d[i]  = 1'b1;
                    pend_rep_d[i] = ev_rep[i];
                end else begin
                    drop_d = 1'b1;
                end
            end
        end
        if (!enable) pending_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_q      <= 4'b1111;
            pending_q  <= '0;
            pend_rep_q <= '0;
            ptr_q      <= '0;
            dropped    <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            key_q      <= keyIn;
            pending_q  <= pending_d;
            pend_rep_q <= pend_rep_d;
            dropped    <= drop_d;
            if (load) ptr_q <= gnt_idx + 2'd1;
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd.cmd_valid  <= 1'b0;
            cmd.cmd_key    <= '0;
            cmd.cmd_repeat <= 1'b0;
        end else if (load) begin
            cmd.cmd_valid  <= 1'b1;
            cmd.cmd_key    <= gnt_idx;
            cmd.cmd_repeat <= pend_rep_q[gnt_idx];
        end else if (cmd.cmd_valid && cmd.cmd_ready) begin
            cmd.cmd_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_key_command_scheduler.sv
// Directed bench for key_command_scheduler with short repeat timing (8/4).
module tb_key_command_scheduler;
    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] keyIn   = 4'b0000;
    logic       enable  = 1'b0;
    logic       dropped;

    key_command_scheduler_if bus ();

    key_command_scheduler #(.CNT_W(8), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .keyIn   (keyIn),
        .enable  (enable),
        .dropped (dropped),
        .cmd     (bus.master)
    );

    always #5 clock = ~clock;

    typedef struct {int cyc; int key; int rep;} rec_t;
    rec_t log_q[$];
    int   cyc      = 0;
    int   drop_cnt = 0;
    int   nvec     = 0;
    int   nerr     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Every accepted command and every dropped pulse, seen mid-cycle
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.cmd_valid && bus.cmd_ready)
                log_q.push_back('{cyc, int'(bus.cmd_key), int'(bus.cmd_repeat)});
            if (dropped) drop_cnt <= drop_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int r, b, db;
    int hold_off [7] = '{2, 10, 14, 18, 22, 26, 30};

    initial begin
        bus.cmd_ready = 1'b1;
        enable        = 1'b1;
        tick(2);
        chk("rst_valid",  bus.cmd_valid,  0);
        chk("rst_key",    bus.cmd_key,    0);
        chk("rst_repeat", bus.cmd_repeat, 0);
        chk("rst_dropped", dropped,       0);
        reset_n = 1'b1;
        tick(2);

        // single press, 3 cycles
        b = log_q.size(); r = cyc;
        keyIn = 4'b0100; tick(3); keyIn = 4'b0000; tick(6);
        chk("single_n", log_q.size() - b, 1);
        if (log_q.size() > b) begin
            chk("single_lat", log_q[b].cyc - r, 2);
            chk("single_key", log_q[b].key, 2);
            chk("single_rep", log_q[b].rep, 0);
        end

        // hold key0 for 30 cycles
        b = log_q.size(); r = cyc;
        keyIn = 4'b0001; tick(30); keyIn = 4'b0000; tick(4);
        chk("hold_n", log_q.size() - b, 7);
        for (int i = 0; i < 7; i++) begin
            if (log_q.size() > b + i) begin
                chk("hold_time", log_q[b+i].cyc - r, hold_off[i]);
                chk("hold_key",  log_q[b+i].key, 0);
                chk("hold_rep",  log_q[b+i].rep, (i == 0) ? 0 : 1);
            end
        end

        // simultaneous 0,1,3 with ptr=0, then round-robin fairness
        reset_n = 1'b0; tick(1); reset_n = 1'b1; tick(2);
        b = log_q.size(); r = cyc;
        keyIn = 4'b1011; tick(1); keyIn = 4'b0000; tick(5);
        chk("sim_n", log_q.size() - b, 3);
        if (log_q.size() >= b + 3) begin
            chk("sim_k0", log_q[b].key,   0);
            chk("sim_k1", log_q[b+1].key, 1);
            chk("sim_k2", log_q[b+2].key, 3);
            chk("sim_t0", log_q[b].cyc - r,   2);
            chk("sim_t2", log_q[b+2].cyc - r, 4);
        end
        keyIn = 4'b0010; tick(1); keyIn = 4'b0000; tick(4);
        b = log_q.size(); r = cyc;
        keyIn = 4'b0101; tick(1); keyIn = 4'b0000; tick(5);
        chk("rr_n", log_q.size() - b, 2);
        if (log_q.size() >= b + 2) begin
            chk("rr_first",  log_q[b].key,   2);
            chk("rr_second", log_q[b+1].key, 0);
            chk("rr_t", log_q[b+1].cyc - r, 3);
        end

        // backpressure: press, re-press (pending), re-press (dropped)
        b = log_q.size(); db = drop_cnt;
        bus.cmd_ready = 1'b0;
        keyIn = 4'b0010; tick(1);
        keyIn = 4'b0000; tick(1);
        keyIn = 4'b0010; tick(1);
        keyIn = 4'b0000; tick(1);
        keyIn = 4'b0010; tick(1);
        keyIn = 4'b0000;
        chk("bp_dropped", dropped, 1);
        chk("bp_valid",   bus.cmd_valid, 1);
        chk("bp_key",     bus.cmd_key, 1);
        tick(1);
        chk("bp_drop_pulse", dropped, 0);
        chk("bp_key_hold",   bus.cmd_key, 1);
        bus.cmd_ready = 1'b1; tick(4);
        chk("bp_n", log_q.size() - b, 2);
        chk("bp_drops", drop_cnt - db, 1);
        if (log_q.size() >= b + 2) begin
            chk("bp_key0", log_q[b].key, 1);
            chk("bp_key1", log_q[b+1].key, 1);
            chk("bp_rep1", log_q[b+1].rep, 0);
        end

        // enable low flushes pending, output still completes
        b = log_q.size();
        bus.cmd_ready = 1'b0;
        keyIn = 4'b0011; tick(1); keyIn = 4'b0000; tick(2);
        enable = 1'b0; tick(2); enable = 1'b1;
        bus.cmd_ready = 1'b1; tick(4);
        chk("en_flush_n", log_q.size() - b, 1);

        // key3 held through reset and an enable toggle
        b = log_q.size();
        reset_n = 1'b0; keyIn = 4'b1000; tick(1);
        reset_n = 1'b1; tick(4);
        enable = 1'b0; tick(2); enable = 1'b1; tick(4);
        chk("held_none", log_q.size() - b, 0);
        keyIn = 4'b0000; tick(1);
        r = cyc;
        keyIn = 4'b1000; tick(2); keyIn = 4'b0000; tick(4);
        chk("repress_n", log_q.size() - b, 1);
        if (log_q.size() > b) begin
            chk("repress_key", log_q[b].key, 3);
            chk("repress_lat", log_q[b].cyc - r, 2);
        end

        // reset mid-handshake
        bus.cmd_ready = 1'b0;
        keyIn = 4'b0100; tick(1); keyIn = 4'b0000; tick(2);
        chk("mid_valid_pre", bus.cmd_valid, 1);
        reset_n = 1'b0; #1;
        chk("mid_valid_rst", bus.cmd_valid, 0);
        chk("mid_key_rst",   bus.cmd_key, 0);
        tick(1); reset_n = 1'b1;
        b = log_q.size();
        bus.cmd_ready = 1'b1; tick(4);
        chk("mid_none", log_q.size() - b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
